// File: rtl/datamem_arbiter_if.sv
// Requester, response and memory-side signals of the datamem arbiter, one bundle.
// slave = arbiter side; master = requesters plus the datamem itself.
interface datamem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              we0;
    logic              we1;
    logic [2:0]        func3_0;
    logic [2:0]        func3_1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_en;
    logic [2:0]        mem_func3;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, func3_0, func3_1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err, busy,
        output mem_address, mem_write_en, mem_func3, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output req0, req1, addr0, addr1, we0, we1, func3_0, func3_1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err, busy,
        input  mem_address, mem_write_en, mem_func3, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port arbiter/sequencer for datamem; ARB_ROUND_ROBIN_EN selects round-robin, else port 0 fixed priority.
// Latency: accept N, memory access N+1, rvalid N+2. Backpressure: combinational gnt, requester holds req until granted.
module datamem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    datamem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        func3_q;
    logic [DATA_W-1:0] wdata_q;
    logic              port_q;
    logic              err_q;
    logic              wen_q;
    logic              busy_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              err_out_q;
    logic [DATA_W-1:0] rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_q;
`endif

    logic              arb_en;
    logic              sel1;
    logic              accept;
    logic [ADDR_W-1:0] addr_d;
    logic              we_d;
    logic [2:0]        func3_d;
    logic [DATA_W-1:0] wdata_d;
    logic              illegal_d;

    function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok_code;
        logic ok_align;
        ok_code = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                     : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (f3[1:0])
            2'b01:   ok_align = ~a[0];
            2'b10:   ok_align = (a == 2'b00);
            default: ok_align = 1'b1;
        endcase
        return ok_code & ok_align;
    endfunction

    always_comb begin
        arb_en = ~rst & ((state_q == IDLE) | (state_q == RESP));
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the port that did not win last time goes next.
        sel1 = bus.req1 & (~bus.req0 | ~last_q);
`else
        sel1 = bus.req1 & ~bus.req0;
`endif
        bus.gnt1  = arb_en & sel1;
        bus.gnt0  = arb_en & bus.req0 & ~sel1;
        accept    = bus.gnt0 | bus.gnt1;
        addr_d    = sel1 ? bus.addr1   : bus.addr0;
        we_d      = sel1 ? bus.we1     : bus.we0;
        func3_d   = sel1 ? bus.func3_1 : bus.func3_0;
        wdata_d   = sel1 ? bus.wdata1  : bus.wdata0;
        illegal_d = ~legal(we_d, func3_d, addr_d[1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            func3_q   <= 3'b000;
            wdata_q   <= '0;
            port_q    <= 1'b0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_out_q <= 1'b0;
            rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_out_q <= 1'b0;
            wen_q     <= 1'b0;
            if (accept) begin
                addr_q  <= addr_d;
                we_q    <= we_d;
                func3_q <= func3_d;
                wdata_q <= wdata_d;
                port_q  <= sel1;
                err_q   <= illegal_d;
`ifdef ARB_ROUND_ROBIN_EN
                last_q  <= sel1;
`endif
            end
            case (state_q)
                ACCESS: begin
                    state_q   <= RESP;
                    rdata_q   <= (~we_q & ~err_q) ? bus.mem_data_out : '0;
                    rvalid0_q <= ~port_q;
                    rvalid1_q <= port_q;
                    err_out_q <= err_q;
                end
                default: begin
                    // IDLE and RESP both arbitrate; RESP chains straight into the next access.
                    if (accept) begin
                        state_q <= ACCESS;
                        wen_q   <= we_d & ~illegal_d;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.mem_address  = addr_q;
    assign bus.mem_write_en = wen_q;
    assign bus.mem_func3    = func3_q;
    assign bus.mem_data_in  = wdata_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.rdata        = rdata_q;
    assign bus.err          = err_out_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: byte-addressed datamem model, table of requests, scoreboard of responses.
module tb_datamem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datamem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    datamem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] dmem [0:255] = '{default: 8'h00};
    logic [7:0] ma0, ma1, ma2, ma3;

    always_comb begin
        ma0 = bus.mem_address[7:0];
        ma1 = ma0 + 8'd1;
        ma2 = ma0 + 8'd2;
        ma3 = ma0 + 8'd3;
        bus.mem_data_out = 32'h0;
        case (bus.mem_func3)
            3'b000: bus.mem_data_out = {{24{dmem[ma0][7]}}, dmem[ma0]};
            3'b001: bus.mem_data_out = {{16{dmem[ma1][7]}}, dmem[ma1], dmem[ma0]};
            3'b010: bus.mem_data_out = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma0]};
            3'b100: bus.mem_data_out = {24'h0, dmem[ma0]};
            3'b101: bus.mem_data_out = {16'h0, dmem[ma1], dmem[ma0]};
            default: bus.mem_data_out = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            dmem[ma0] <= bus.mem_data_in[7:0];
            if (bus.mem_func3[1:0] != 2'b00) dmem[ma1] <= bus.mem_data_in[15:8];
            if (bus.mem_func3[1:0] == 2'b10) begin
                dmem[ma2] <= bus.mem_data_in[23:16];
                dmem[ma3] <= bus.mem_data_in[31:24];
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[14];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wen_cnt = 0;
    int   rv_cnt = 0;
    int   busy_drops = 0;
    bit   busy_watch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic p, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.port = p; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.mem_write_en) wen_cnt++;
            if (busy_watch && !bus.busy) busy_drops++;
            if (bus.rvalid0 || bus.rvalid1) begin
                rv_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rvalid: got rvalid=%b%b, want none (cycle %0d)",
                             bus.rvalid1, bus.rvalid0, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_port", {30'h0, bus.rvalid1, bus.rvalid0}, e.port ? 32'h2 : 32'h1);
                    chk("rdata", bus.rdata, e.rdata);
                    chk("err", {31'h0, bus.err}, {31'h0, e.err});
                    chk("rvalid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic p, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input bit push,
                         output int acc);
        exp_t e;
        @(negedge clk);
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.func3_1 = f3; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.func3_0 = f3; bus.addr0 = a; bus.wdata0 = wd;
        end
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (p ? bus.gnt1 : bus.gnt0) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: got no grant for port %0d, want grant within 20 cycles", p);
        end else if (push) begin
            e.port = p; e.rdata = er; e.err = ee; e.cyc = acc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int acc1, acc2, acc, grants, prev, rv_before;
        logic exp_p;
        exp_t e;

        tbl[0]  = mk(1'b0, 1'b1, 3'b010, 32'h04, 32'hAABBCCDD, 32'h0,        1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 3'b010, 32'h04, 32'h0,       32'hAABBCCDD, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 3'b000, 32'h05, 32'h000000EE, 32'h0,       1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 3'b000, 32'h05, 32'h0,       32'hFFFFFFEE, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 3'b100, 32'h05, 32'h0,       32'h000000EE, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 3'b010, 32'h04, 32'h0,       32'hAABBEEDD, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 3'b001, 32'h05, 32'h00001111, 32'h0,       1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 3'b010, 32'h06, 32'h22222222, 32'h0,       1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 3'b010, 32'h04, 32'h0,       32'hAABBEEDD, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 3'b011, 32'h04, 32'h0,       32'h0,        1'b1);
        tbl[10] = mk(1'b0, 1'b0, 3'b001, 32'h06, 32'h0,       32'hFFFFAABB, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 3'b100, 32'h04, 32'h33333333, 32'h0,       1'b1);
        tbl[12] = mk(1'b0, 1'b0, 3'b101, 32'h04, 32'h0,       32'h0000EEDD, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 3'b010, 32'h01, 32'h0,       32'h0,        1'b1);

        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = '0; bus.addr1 = '0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.func3_0 = 3'b010; bus.func3_1 = 3'b010; bus.wdata0 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("gnt_in_reset", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_flags", {27'h0, bus.rvalid0, bus.rvalid1, bus.err, bus.busy, bus.mem_write_en}, 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_mem_address", bus.mem_address, 32'h0);
        chk("reset_mem_func3", {29'h0, bus.mem_func3}, 32'h0);
        chk("reset_mem_data_in", bus.mem_data_in, 32'h0);

        for (int i = 0; i < 14; i++)
            issue(tbl[i].port, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                  tbl[i].exp_rdata, tbl[i].exp_err, 1'b1, acc);
        drain();
        chk("legal_store_writes", wen_cnt, 32'd2);

        // Store then load chained through RESP with no idle gap.
        issue(1'b0, 1'b1, 3'b010, 32'h08, 32'h12345678, 32'h0, 1'b0, 1'b1, acc1);
        busy_watch = 1'b1;
        issue(1'b0, 1'b0, 3'b010, 32'h08, 32'h0, 32'h12345678, 1'b0, 1'b1, acc2);
        chk("resp_accept_gap", acc2 - acc1, 32'd2);
        drain();
        busy_watch = 1'b0;
        chk("busy_held", busy_drops, 32'd0);

        // Reset in the middle of an ACCESS cycle.
        issue(1'b1, 1'b1, 3'b010, 32'h0C, 32'h55555555, 32'h0, 1'b0, 1'b0, acc);
        rv_before = rv_cnt;
        chk("wen_in_access", {31'h0, bus.mem_write_en}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_flags", {27'h0, bus.rvalid0, bus.rvalid1, bus.err, bus.busy, bus.mem_write_en}, 32'h0);
        chk("midreset_mem_address", bus.mem_address, 32'h0);
        chk("midreset_rdata", bus.rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("idle_after_reset", {31'h0, bus.busy}, 32'h0);
        chk("no_rvalid_after_reset", rv_cnt, rv_before);

        // Both ports requesting continuously.
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.func3_0 = 3'b010; bus.addr0 = 32'h04;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.func3_1 = 3'b010; bus.addr1 = 32'h04;
        grants = 0;
        prev = -1;
        for (int i = 0; i < 30 && grants < 4; i++) begin
            #1;
            if (bus.gnt0 || bus.gnt1) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_p = grants[0];
`else
                exp_p = 1'b0;
`endif
                chk("gnt_onehot", {31'h0, bus.gnt0 & bus.gnt1}, 32'h0);
                chk("contention_port", {31'h0, bus.gnt1}, {31'h0, exp_p});
                if (prev >= 0) chk("contention_gap", cyc - prev, 32'd2);
                prev = cyc;
                e.port = bus.gnt1; e.rdata = 32'hAABBEEDD; e.err = 1'b0; e.cyc = cyc + 2;
                sb.push_back(e);
                grants++;
            end
            @(negedge clk);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("contention_grants", grants, 32'd4);
        drain();
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
